ae_seq_core: RTL and testbench

Parametrised, self-sequencing autoencoder execution core. It fetches 16-bit-class instructions from an external program ROM and executes fixed-point arithmetic and activation operations against an internal register file. It supports multiply-accumulate, a hardware loop counter, halt, and a start/done handshake. It replaces the free-running, single-width datapath and sits between the host/controller and the program ROM in the autoencoder top level.

---
 rtl/ae_seq_core.sv | 193 +++++++++++++++++++
 tb/tb_ae_seq_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ae_seq_core.sv
// Self-sequencing fixed-point autoencoder core: fetches instructions from an external ROM and executes them on a register file.
// Latency: 2 cycles per instruction (FETCH, EXEC); done pulses the cycle after HALT executes.
// Backpressure: none; start is taken only in IDLE and host writes are dropped while busy.
//
// Ports: clock/reset (async active-high); start/busy/done/illegal run control and status;
// pc and instr_addr (ROM address, equal to pc); instr_data (combinational ROM data);
// host_we/host_addr/host_wdata/host_rdata give host access to the register file.
module ae_seq_core #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 5,
    localparam int INSTR_W = 4 + 3 * ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [DATA_W-1:0]  host_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int IMM_W = 2 * ADDR_W;
    // Intermediate width: wide enough for any sum or shifted product before saturation.
    localparam int WW    = 2 * DATA_W + 2;

    localparam logic signed [WW-1:0] SAT_HI = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_LO = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] HALF = ONE >> 1;
    localparam logic [DATA_W-1:0] C58  = DATA_W'(5) << (FRAC_W - 3);   // 5/8
    localparam logic [DATA_W-1:0] C27  = DATA_W'(27) << (FRAC_W - 5);  // 27/32
    // Breakpoints compared in a wider field because 5*ONE may not fit DATA_W.
    localparam logic [DATA_W+2:0] T_ONE = (DATA_W+3)'(1) << FRAC_W;
    localparam logic [DATA_W+2:0] T_19  = (DATA_W+3)'(19) << (FRAC_W - 3);
    localparam logic [DATA_W+2:0] T_5   = (DATA_W+3)'(5) << FRAC_W;

    localparam logic [3:0] OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3,
                           OP_ADDR = 4'd4,  OP_MULR = 4'd5,  OP_SIG  = 4'd6,
                           OP_DSIG = 4'd7,  OP_MAC  = 4'd8,  OP_SETC = 4'd9,
                           OP_DJNZ = 4'd10, OP_HALT = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

    state_t              state, state_nxt;
    logic [INSTR_W-1:0]  ir;
    logic [IMM_W-1:0]    loop_cnt;
    logic [DATA_W-1:0]   regs [DEPTH];

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   ra_idx, rb_idx, rd_idx;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   ra_val, rb_val, rd_val, res;
    logic                wr_en;

    function automatic logic signed [WW-1:0] sx(input logic [DATA_W-1:0] v);
        return {{(WW-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
        if (v > SAT_HI)      return MAX_D;
        else if (v < SAT_LO) return MIN_D;
        else                 return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

    // Full-width product, arithmetic shift (floor), then saturate.
    function automatic logic [DATA_W-1:0] fx_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] ae, be, p, sh;
        ae = {{DATA_W{a[DATA_W-1]}}, a};
        be = {{DATA_W{b[DATA_W-1]}}, b};
        p  = ae * be;
        sh = p >>> FRAC_W;
        return sat({{2{sh[2*DATA_W-1]}}, sh});
    endfunction

    function automatic logic [DATA_W-1:0] sigmoid(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] a, y;
        logic [DATA_W+2:0] aw;
        if (x == MIN_D)       a = MAX_D;        // |min| is not representable
        else if (x[DATA_W-1]) a = ~x + DATA_W'(1);
        else                  a = x;
        aw = {3'b000, a};
        if (aw >= T_5)        y = ONE;
        else if (aw >= T_19)  y = (a >> 5) + C27;
        else if (aw >= T_ONE) y = (a >> 3) + C58;
        else                  y = (a >> 2) + HALF;
        return x[DATA_W-1] ? ONE - y : y;
    endfunction

    assign busy       = (state != S_IDLE);
    assign instr_addr = pc;
    assign host_rdata = regs[host_addr];

    assign opcode = ir[INSTR_W-1 -: 4];
    assign ra_idx = ir[3*ADDR_W-1:2*ADDR_W];
    assign rb_idx = ir[2*ADDR_W-1:ADDR_W];
    assign rd_idx = ir[ADDR_W-1:0];
    assign imm    = ir[2*ADDR_W-1:0];
    assign ra_val = regs[ra_idx];
    assign rb_val = regs[rb_idx];
    assign rd_val = regs[rd_idx];

    // Datapath: result and write enable for the instruction held in ir.
    always_comb begin
        res   = '0;
        wr_en = 1'b0;
        case (opcode)
            OP_ADD:  begin res = sat(sx(ra_val) + sx(rb_val));                     wr_en = 1'b1; end
            OP_SUB:  begin res = sat(sx(ra_val) - sx(rb_val));                     wr_en = 1'b1; end
            OP_MUL:  begin res = fx_mul(ra_val, rb_val);                           wr_en = 1'b1; end
            OP_ADDR: begin res = relu(sat(sx(ra_val) + sx(rb_val)));               wr_en = 1'b1; end
            OP_MULR: begin res = relu(fx_mul(ra_val, rb_val));                     wr_en = 1'b1; end
            OP_SIG:  begin res = sigmoid(ra_val);                                  wr_en = 1'b1; end
            OP_DSIG: begin res = fx_mul(ra_val, sat(sx(ONE) - sx(ra_val)));        wr_en = 1'b1; end
            OP_MAC:  begin res = sat(sx(rd_val) + sx(fx_mul(ra_val, rb_val)));     wr_en = 1'b1; end
            default: begin res = '0;                                               wr_en = 1'b0; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (opcode == OP_HALT) ? S_IDLE : S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            loop_cnt <= '0;
            ir       <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host_we) regs[host_addr] <= host_wdata;
                    if (start) begin
                        pc       <= '0;
                        loop_cnt <= '0;
                        illegal  <= 1'b0;
                    end
                end
                S_FETCH: ir <= instr_data;
                S_EXEC: begin
                    if (wr_en) regs[rd_idx] <= res;
                    pc <= pc + PC_W'(1);
                    case (opcode)
                        OP_SETC: loop_cnt <= imm;
                        OP_DJNZ: begin
                            if (loop_cnt > IMM_W'(1)) begin
                                loop_cnt <= loop_cnt - IMM_W'(1);
                                pc       <= imm[PC_W-1:0];
                            end else begin
                                loop_cnt <= '0;
                            end
                        end
                        OP_HALT: begin
                            pc   <= pc;
                            done <= 1'b1;
                        end
                        4'd11, 4'd12, 4'd13, 4'd14: illegal <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ae_seq_core.sv
// Directed testbench for ae_seq_core: arithmetic, saturation, activations, loop, illegal opcode,
// host-write protection and mid-run reset, checked with immediate assertions.
module tb_ae_seq_core;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int PC_W    = 5;
    localparam int INSTR_W = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic               busy, done, illegal;
    logic [PC_W-1:0]    pc, instr_addr;
    logic [INSTR_W-1:0] instr_data;
    logic               host_we;
    logic [ADDR_W-1:0]  host_addr;
    logic [DATA_W-1:0]  host_wdata, host_rdata;

    logic [INSTR_W-1:0] rom [32];
    assign instr_data = rom[instr_addr];

    int checks = 0;
    int errors = 0;

    ae_seq_core dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .pc         (pc),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd);
        return {op, ra, rb, rd};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        host_addr = a;
        #1;
        chk(tag, {16'h0, host_rdata}, {16'h0, exp});
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    // Counts busy samples from now until busy drops, then checks the single done pulse.
    task automatic wait_done(input string tag, input int exp_busy);
        int n;
        n = 0;
        while (busy && n < 400) begin
            n++;
            tick();
        end
        chk({tag, " busy cycles"}, n, exp_busy);
        chk({tag, " done pulse"}, {31'h0, done}, 32'h1);
        chk({tag, " busy low at done"}, {31'h0, busy}, 32'h0);
        tick();
        chk({tag, " done one cycle"}, {31'h0, done}, 32'h0);
    endtask

    task automatic run_prog(input string tag, input int exp_busy);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(tag, exp_busy);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        clear_rom();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        chk("reset illegal", {31'h0, illegal}, 32'h0);
        chk("reset pc", {27'h0, pc}, 32'h0);
        chk_reg("reset r0", 4'd0, 16'h0000);

        // MUL: 1.5 * 2.0 = 3.0
        host_wr(4'd0, 16'h0180);
        host_wr(4'd1, 16'h0200);
        clear_rom();
        rom[0] = enc(4'd3, 4'd0, 4'd1, 4'd2);
        rom[1] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        run_prog("mul", 4);
        chk_reg("mul r2", 4'd2, 16'h0300);

        // Saturation, floor shift, aliasing
        host_wr(4'd3, 16'h7F00);
        host_wr(4'd4, 16'h0200);
        host_wr(4'd5, 16'h8000);
        host_wr(4'd6, 16'h0100);
        host_wr(4'd7, 16'hFF00);
        host_wr(4'd8, 16'h0080);
        host_wr(4'd12, 16'hFFFF);
        host_wr(4'd13, 16'h0001);
        clear_rom();
        rom[0] = enc(4'd1, 4'd3, 4'd4, 4'd9);    // ADD  -> 7FFF
        rom[1] = enc(4'd2, 4'd5, 4'd6, 4'd10);   // SUB  -> 8000
        rom[2] = enc(4'd4, 4'd7, 4'd8, 4'd11);   // ADDR -> 0000
        rom[3] = enc(4'd3, 4'd12, 4'd13, 4'd14); // MUL -1 lsb * 1 lsb floors to FFFF
        rom[4] = enc(4'd1, 4'd4, 4'd4, 4'd4);    // ADD alias -> 0400
        rom[5] = enc(4'd3, 4'd3, 4'd3, 4'd15);   // MUL large -> 7FFF
        rom[6] = enc(4'd5, 4'd5, 4'd6, 4'd1);    // MULR negative -> 0000
        rom[7] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        run_prog("sat", 16);
        chk_reg("add sat", 4'd9, 16'h7FFF);
        chk_reg("sub sat", 4'd10, 16'h8000);
        chk_reg("addr relu", 4'd11, 16'h0000);
        chk_reg("mul floor", 4'd14, 16'hFFFF);
        chk_reg("add alias", 4'd4, 16'h0400);
        chk_reg("mul sat", 4'd15, 16'h7FFF);
        chk_reg("mulr relu", 4'd1, 16'h0000);

        // Activations
        host_wr(4'd12, 16'h0000);
        host_wr(4'd13, 16'h0600);
        host_wr(4'd14, 16'hFF00);
        host_wr(4'd15, 16'h0080);
        host_wr(4'd11, 16'h0300);
        host_wr(4'd10, 16'hFD00);
        host_wr(4'd9, 16'h0040);
        host_wr(4'd8, 16'h8000);
        clear_rom();
        rom[0] = enc(4'd6, 4'd12, 4'd0, 4'd0);
        rom[1] = enc(4'd6, 4'd13, 4'd0, 4'd1);
        rom[2] = enc(4'd6, 4'd14, 4'd0, 4'd2);
        rom[3] = enc(4'd7, 4'd15, 4'd0, 4'd3);
        rom[4] = enc(4'd6, 4'd11, 4'd0, 4'd4);
        rom[5] = enc(4'd6, 4'd10, 4'd0, 4'd5);
        rom[6] = enc(4'd6, 4'd9, 4'd0, 4'd6);
        rom[7] = enc(4'd6, 4'd8, 4'd0, 4'd7);
        rom[8] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        run_prog("act", 18);
        chk_reg("sig 0", 4'd0, 16'h0080);
        chk_reg("sig 6.0", 4'd1, 16'h0100);
        chk_reg("sig -1.0", 4'd2, 16'h0040);
        chk_reg("dsig 0.5", 4'd3, 16'h0040);
        chk_reg("sig 3.0", 4'd4, 16'h00F0);
        chk_reg("sig -3.0", 4'd5, 16'h0010);
        chk_reg("sig 0.25", 4'd6, 16'h0090);
        chk_reg("sig min", 4'd7, 16'h0000);

        // Hardware loop with MAC
        host_wr(4'd0, 16'h0100);
        host_wr(4'd1, 16'h0080);
        host_wr(4'd2, 16'h0000);
        clear_rom();
        rom[0] = enc(4'd9, 4'd0, 4'd0, 4'd3);
        rom[1] = enc(4'd8, 4'd0, 4'd1, 4'd2);
        rom[2] = enc(4'd10, 4'd0, 4'd0, 4'd1);
        rom[3] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        run_prog("loop", 16);
        chk_reg("loop r2", 4'd2, 16'h0180);

        // Illegal opcode, host write ignored while busy
        host_wr(4'd5, 16'h1234);
        clear_rom();
        rom[0] = enc(4'd12, 4'd0, 4'd0, 4'd0);
        rom[1] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy at host write", {31'h0, busy}, 32'h1);
        host_wr(4'd5, 16'hBEEF);
        wait_done("illegal", 3);
        chk("illegal sticky", {31'h0, illegal}, 32'h1);
        chk_reg("protected r5", 4'd5, 16'h1234);
        clear_rom();
        rom[0] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("illegal cleared", {31'h0, illegal}, 32'h0);
        chk("pc after start", {27'h0, pc}, 32'h0);
        wait_done("halt only", 2);

        // Reset during the third EXEC
        host_wr(4'd1, 16'h0011);
        clear_rom();
        rom[0] = enc(4'd1, 4'd1, 4'd1, 4'd2);
        rom[1] = enc(4'd1, 4'd2, 4'd2, 4'd3);
        rom[2] = enc(4'd1, 4'd3, 4'd3, 4'd4);
        rom[3] = enc(4'd15, 4'd0, 4'd0, 4'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pc in exec2", {27'h0, pc}, 32'h2);
        chk_reg("r3 before reset", 4'd3, 16'h0044);
        reset = 1'b1;
        #1;
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort done", {31'h0, done}, 32'h0);
        chk("abort pc", {27'h0, pc}, 32'h0);
        chk_reg("abort r1", 4'd1, 16'h0000);
        chk_reg("abort r3", 4'd3, 16'h0000);
        reset = 1'b0;
        tick();
        chk("no done after abort", {31'h0, done}, 32'h0);
        host_wr(4'd1, 16'h0011);
        run_prog("rerun", 8);
        chk_reg("rerun r4", 4'd4, 16'h0088);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
